tftlcd_axil_regfile: RTL and testbench

- Parametrised AXI4-Lite slave register file for the TFT-LCD controller.
- Successor to the fixed 4-register slave. Generalises register count, adds:
  - byte-strobe writes
  - read-only status registers
  - a write-1-to-clear interrupt register
  - SLVERR decode
  - per-register write strobes
- Sits between the processor interconnect and the LCD timing/pixel logic.

---
 rtl/tftlcd_axil_regfile_if.sv | 36 +++
 rtl/tftlcd_axil_regfile.sv | 169 ++++++++++++++++
 tb/tb_tftlcd_axil_regfile.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tftlcd_axil_regfile_if.sv
// AXI4-Lite slave bus bundle for the TFT-LCD register file.
interface tftlcd_axil_regfile_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/tftlcd_axil_regfile.sv
// Parametrised AXI4-Lite register file: RW, read-only status and W1C interrupt registers.
module tftlcd_axil_regfile #(
  parameter int unsigned         NUM_REGS   = 16,
  parameter int unsigned         ADDR_WIDTH = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  parameter int unsigned         IRQ_IDX    = NUM_REGS - 1
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  tftlcd_axil_regfile_if.slave   s_axi,
  output logic [NUM_REGS*32-1:0] reg_out,
  input  logic [NUM_REGS*32-1:0] reg_in,
  output logic [NUM_REGS-1:0]    wr_pulse,
  input  logic [31:0]            irq_set,
  output logic                   irq
);

  localparam int unsigned IW     = ADDR_WIDTH - 2;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic                         aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IW-1:0]                aw_idx_q, aw_idx_d;
  logic [31:0]                  wdata_q, wdata_d, wmask;
  logic [3:0]                   wstrb_q, wstrb_d;
  logic                         awready_q, awready_d, wready_q, wready_d;
  logic                         bvalid_q, bvalid_d;
  logic [1:0]                   bresp_q, bresp_d;
  logic                         arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic [1:0]                   rresp_q, rresp_d;
  logic [NUM_REGS-1:0][31:0]    regs_q, regs_d;
  logic [NUM_REGS-1:0]          wr_pulse_q, wr_pulse_d;
  logic                         irq_q;
  logic                         unused_bits;

  // Protection bits and the byte offset are don't-care; reg_in is only read for RO slots.
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0],
                         reg_in};

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign reg_out       = regs_q;
  assign wr_pulse      = wr_pulse_q;
  assign irq           = irq_q;

  // Write path: latch AW/W independently; commit on the edge where both become held.
  always_comb begin
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    wmask      = '0;

    if (s_axi.awvalid && awready_q) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_axi.awaddr[ADDR_WIDTH-1:2];
    end
    if (s_axi.wvalid && wready_q) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi.wdata;
      wstrb_d  = s_axi.wstrb;
    end

    for (int unsigned k = 0; k < 4; k++) wmask[8*k +: 8] = {8{wstrb_d[k]}};

    regs_d[IRQ_IDX] = regs_q[IRQ_IDX] | irq_set;

    if (aw_held_d && w_held_d && !bvalid_q) begin
      bvalid_d = 1'b1;
      bresp_d  = SLVERR;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (aw_idx_d == IW'(i)) begin
          bresp_d       = OKAY;
          wr_pulse_d[i] = 1'b1;
          if (i == IRQ_IDX) begin
            // A set arriving in the commit cycle beats the clear.
            regs_d[i] = (regs_q[i] & ~(wdata_d & wmask)) | irq_set;
          end else if (!RO_MASK[i]) begin
            regs_d[i] = (regs_q[i] & ~wmask) | (wdata_d & wmask);
          end
        end
      end
    end

    if (bvalid_q && s_axi.bready) begin
      bvalid_d  = 1'b0;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end

    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
  end

  // Read path: capture data/response at the AR handshake and hold until RREADY.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    if (rvalid_q && s_axi.rready) rvalid_d = 1'b0;

    if (s_axi.arvalid && arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = SLVERR;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (s_axi.araddr[ADDR_WIDTH-1:2] == IW'(i)) begin
          rresp_d = OKAY;
          rdata_d = RO_MASK[i] ? reg_in[32*i +: 32] : regs_q[i];
        end
      end
    end

    arready_d = !rvalid_d;
  end

  // State registers; reset also drops any half-latched write.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
      regs_q     <= '0;
      wr_pulse_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      irq_q      <= |regs_q[IRQ_IDX];
    end
  end

endmodule

// File: tb/tb_tftlcd_axil_regfile.sv
// Scoreboard bench for tftlcd_axil_regfile: expected responses queued at issue, checked on B/R.
module tb_tftlcd_axil_regfile;

  localparam int unsigned NR  = 16;
  localparam int unsigned AW  = 8;
  localparam int unsigned IRQ = NR - 1;
  localparam logic [NR-1:0] RO = 16'h0008;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } rd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tftlcd_axil_regfile_if #(.ADDR_WIDTH(AW)) bus ();

  logic [NR*32-1:0] reg_out, reg_in;
  logic [NR-1:0]    wr_pulse;
  logic [31:0]      irq_set;
  logic             irq;

  tftlcd_axil_regfile #(
    .NUM_REGS  (NR),
    .ADDR_WIDTH(AW),
    .RO_MASK   (RO),
    .IRQ_IDX   (IRQ)
  ) dut (
    .ACLK    (clk),
    .ARESETN (rst_n),
    .s_axi   (bus.slave),
    .reg_out (reg_out),
    .reg_in  (reg_in),
    .wr_pulse(wr_pulse),
    .irq_set (irq_set),
    .irq     (irq)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model [NR];
  logic [1:0]  bq [$];
  rd_t         rq [$];
  int          pulse_cnt [NR];
  int          snap [NR];

  initial for (int i = 0; i < int'(NR); i++) pulse_cnt[i] = 0;

  // Count per-register write pulses mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < int'(NR); i++) if (wr_pulse[i]) pulse_cnt[i]++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model_write(input logic [7:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb, input logic [31:0] set);
    int          idx = int'(addr[7:2]);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{strb[k]}};
    if (idx >= int'(NR)) return 2'b10;
    if (idx == int'(IRQ)) model[idx] = (model[idx] & ~(data & m)) | set;
    else if (!RO[idx]) model[idx] = (model[idx] & ~m) | (data & m);
    return 2'b00;
  endfunction

  function automatic rd_t model_read(input logic [7:0] addr);
    int  idx = int'(addr[7:2]);
    rd_t e;
    if (idx >= int'(NR)) begin
      e.d = '0;
      e.r = 2'b10;
    end else begin
      e.d = RO[idx] ? reg_in[32*idx +: 32] : model[idx];
      e.r = 2'b00;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic take_snap();
    for (int i = 0; i < int'(NR); i++) snap[i] = pulse_cnt[i];
  endtask

  // Drain one B response, optionally holding BREADY low first.
  task automatic collect_b(input int stall);
    logic [1:0] held;
    bit         got = 0;
    held = bus.bresp;
    for (int c = 0; c < stall; c++) begin
      step();
      check_eq("b_hold_valid", 64'(bus.bvalid), 64'd1);
      check_eq("b_hold_resp", 64'(bus.bresp), 64'(held));
    end
    bus.bready = 1'b1;
    for (int c = 0; c < 40 && !got; c++) begin
      if (bus.bvalid) begin
        got = 1;
        if (bq.size() > 0) check_eq("bresp", 64'(bus.bresp), 64'(bq.pop_front()));
        else check_eq("b_unexpected", 64'd1, 64'd0);
      end
      step();
    end
    bus.bready = 1'b0;
    check_eq("b_seen", 64'(got), 64'd1);
    check_eq("b_dropped", 64'(bus.bvalid), 64'd0);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input int w_lead = 0, input int bstall = 0);
    bit aw_done = 0, w_done = 0, aw_f, w_f;
    int cyc = 0;
    bq.push_back(model_write(addr, data, strb, irq_set));
    bus.awaddr  = addr;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.wvalid  = 1'b1;
    bus.awvalid = (w_lead == 0);
    while (!(aw_done && w_done) && cyc < 40) begin
      aw_f = bus.awvalid && bus.awready;
      w_f  = bus.wvalid && bus.wready;
      step();
      cyc++;
      if (aw_f) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (w_f) begin w_done = 1; bus.wvalid = 1'b0; end
      if (!aw_done) begin
        check_eq("no_early_b", 64'(bus.bvalid), 64'd0);
        if (cyc >= w_lead) bus.awvalid = 1'b1;
      end
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check_eq("wr_handshake", 64'(aw_done && w_done), 64'd1);
    check_eq("bvalid_next", 64'(bus.bvalid), 64'd1);
    collect_b(bstall);
  endtask

  task automatic rd(input logic [7:0] addr, input int rstall = 0);
    bit   done = 0, f;
    rd_t  e;
    logic [31:0] held;
    rq.push_back(model_read(addr));
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      f = bus.arvalid && bus.arready;
      step();
      if (f) done = 1;
    end
    bus.arvalid = 1'b0;
    check_eq("ar_handshake", 64'(done), 64'd1);
    check_eq("rvalid_next", 64'(bus.rvalid), 64'd1);
    held = bus.rdata;
    for (int c = 0; c < rstall; c++) begin
      step();
      check_eq("r_hold_valid", 64'(bus.rvalid), 64'd1);
      check_eq("r_hold_data", 64'(bus.rdata), 64'(held));
    end
    e = rq.pop_front();
    check_eq("rdata", 64'(bus.rdata), 64'(e.d));
    check_eq("rresp", 64'(bus.rresp), 64'(e.r));
    bus.rready = 1'b1;
    step();
    bus.rready = 1'b0;
    check_eq("r_dropped", 64'(bus.rvalid), 64'd0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_awready", 64'(bus.awready), 64'd0);
    check_eq("rst_wready", 64'(bus.wready), 64'd0);
    check_eq("rst_arready", 64'(bus.arready), 64'd0);
    check_eq("rst_bvalid", 64'(bus.bvalid), 64'd0);
    check_eq("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check_eq("rst_rdata", 64'(bus.rdata), 64'd0);
    check_eq("rst_wr_pulse", 64'(wr_pulse), 64'd0);
    check_eq("rst_irq", 64'(irq), 64'd0);
    check_eq("rst_reg_out_or", 64'(|reg_out), 64'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    irq_set = '0;
    for (int i = 0; i < int'(NR); i++) begin
      reg_in[32*i +: 32] = 32'hDEAD_0000 | 32'(i);
      model[i] = '0;
    end
    reg_in[32*3 +: 32] = 32'hCAFE_F00D;

    step();
    step();
    check_reset_outputs();
    #2 rst_n = 1'b1;
    step();
    step();

    // Full sweep of every register.
    take_snap();
    for (int i = 0; i < int'(NR); i++) wr(8'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < int'(NR); i++) check_eq("pulse_once", 64'(pulse_cnt[i] - snap[i]), 64'd1);
    for (int i = 0; i < int'(NR); i++) rd(8'(i * 4));

    // Byte-strobe merge.
    wr(8'h08, 32'hAABB_CCDD, 4'hF);
    wr(8'h08, 32'h1122_3344, 4'b0101);
    check_eq("merge_out", 64'(reg_out[32*2 +: 32]), 64'h0000_0000_AA22_CC44);
    rd(8'h08);

    // Read-only register ignores the write but still answers OKAY.
    wr(8'h0C, 32'h0, 4'hF);
    rd(8'h0C);

    // Interrupt register: set, W1C, set-beats-clear, full clear.
    irq_set = 32'h5;
    step();
    irq_set = '0;
    model[IRQ] |= 32'h5;
    check_eq("irq_lag", 64'(irq), 64'd0);
    step();
    check_eq("irq_set", 64'(irq), 64'd1);
    wr(8'h3C, 32'h1, 4'hF);
    rd(8'h3C);
    irq_set = 32'h4;
    wr(8'h3C, 32'h4, 4'hF);
    irq_set = '0;
    rd(8'h3C);
    wr(8'h3C, 32'h4, 4'hF);
    rd(8'h3C);
    step();
    step();
    check_eq("irq_clear", 64'(irq), 64'd0);

    // Out-of-range address.
    take_snap();
    wr(8'h40, 32'hFFFF_FFFF, 4'hF);
    rd(8'h40);
    for (int i = 0; i < int'(NR); i++) begin
      check_eq("oor_no_pulse", 64'(pulse_cnt[i] - snap[i]), 64'd0);
      if (!RO[i]) check_eq("oor_regs", 64'(reg_out[32*i +: 32]), 64'(model[i]));
    end

    // W ahead of AW, long back-pressure on B and R.
    take_snap();
    wr(8'h10, 32'h5A5A_1234, 4'hF, 3, 10);
    check_eq("lead_single_pulse", 64'(pulse_cnt[4] - snap[4]), 64'd1);
    rd(8'h10, 10);

    // Reset while an AW is latched: outputs clear at once and the AW is forgotten.
    bus.awaddr  = 8'h14;
    bus.awvalid = 1'b1;
    step();
    check_eq("aw_taken", 64'(bus.awready), 64'd0);
    bus.awvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    for (int i = 0; i < int'(NR); i++) model[i] = '0;
    step();
    #2 rst_n = 1'b1;
    step();
    step();
    take_snap();
    bus.wdata  = 32'h1357_9BDF;
    bus.wstrb  = 4'hF;
    bus.wvalid = 1'b1;
    step();
    bus.wvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check_eq("stale_aw_bvalid", 64'(bus.bvalid), 64'd0);
    end
    check_eq("stale_aw_pulse", 64'(pulse_cnt[5] - snap[5]), 64'd0);
    bq.push_back(model_write(8'h14, 32'h1357_9BDF, 4'hF, 32'h0));
    bus.awaddr  = 8'h14;
    bus.awvalid = 1'b1;
    step();
    bus.awvalid = 1'b0;
    check_eq("late_aw_bvalid", 64'(bus.bvalid), 64'd1);
    collect_b(0);
    rd(8'h14);
    rd(8'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
